// File: rtl/mem_responder_if.sv
// Request/response bundle between the LC-3 control path (MAR/MDR side) and the memory responder.
interface mem_responder_if;
  logic        MEM_EN;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        R;
  logic        BUSY;
  logic        ERR;

  modport master (
    output MEM_EN, WE, ADDR, DATA_IN,
    input  DATA_OUT, R, BUSY, ERR
  );

  modport slave (
    input  MEM_EN, WE, ADDR, DATA_IN,
    output DATA_OUT, R, BUSY, ERR
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: captures a request, waits WAIT_STATES cycles, accesses an internal
// word array and returns registered read data with a one-cycle ready (R) / error (ERR) pulse.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH_LOG2  = 8
) (
  input  logic          Clk,
  input  logic          Reset_al,
  mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [15:0] cap_addr;
  logic [15:0] cap_data;
  logic [15:0] mem [0:DEPTH-1];

  logic        acc_go;
  logic        acc_we;
  logic [15:0] acc_addr;
  logic [15:0] acc_data;
  logic        acc_in_range;

  // With zero wait states the access happens on the capture edge, so it uses the live inputs.
  always_comb begin
    acc_go   = 1'b0;
    acc_we   = cap_we;
    acc_addr = cap_addr;
    acc_data = cap_data;
    if (state == ST_IDLE) begin
      acc_we   = bus.WE;
      acc_addr = bus.ADDR;
      acc_data = bus.DATA_IN;
      acc_go   = bus.MEM_EN && (WS == 4'd0);
    end else if (state == ST_WAIT) begin
      acc_go   = (cnt == 4'd1);
    end
    acc_go       = acc_go && Reset_al;
    acc_in_range = ((acc_addr >> DEPTH_LOG2) == '0);
  end

  // Array is deliberately not reset; contents survive Reset_al.
  always_ff @(posedge Clk) begin
    if (acc_go && acc_we && acc_in_range)
      mem[acc_addr[DEPTH_LOG2-1:0]] <= acc_data;
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_addr     <= '0;
      cap_data     <= '0;
      bus.R        <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.ERR      <= 1'b0;
      bus.DATA_OUT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.MEM_EN) begin
            cap_we   <= bus.WE;
            cap_addr <= bus.ADDR;
            cap_data <= bus.DATA_IN;
            cnt      <= WS;
            bus.BUSY <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        ST_RESP: begin
          bus.R    <= 1'b0;
          bus.ERR  <= 1'b0;
          bus.BUSY <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Access completion overrides the per-state next state (covers the zero-wait IDLE path).
      if (acc_go) begin
        state   <= ST_RESP;
        bus.R   <= 1'b1;
        bus.ERR <= !acc_in_range;
        if (!acc_we)
          bus.DATA_OUT <= acc_in_range ? mem[acc_addr[DEPTH_LOG2-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        rst_a, rst_b;
  logic        sel_b;
  logic        mem_en, we;
  logic [15:0] addr, din;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 Clk = ~Clk;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  assign ifa.MEM_EN  = mem_en & ~sel_b;
  assign ifb.MEM_EN  = mem_en & sel_b;
  assign ifa.WE      = we;
  assign ifb.WE      = we;
  assign ifa.ADDR    = addr;
  assign ifb.ADDR    = addr;
  assign ifa.DATA_IN = din;
  assign ifb.DATA_IN = din;

  logic        r, busy, err;
  logic [15:0] dout;
  assign r    = sel_b ? ifb.R        : ifa.R;
  assign busy = sel_b ? ifb.BUSY     : ifa.BUSY;
  assign err  = sel_b ? ifb.ERR      : ifa.ERR;
  assign dout = sel_b ? ifb.DATA_OUT : ifa.DATA_OUT;

  mem_responder #(.WAIT_STATES(2), .DEPTH_LOG2(8)) dut_a (
    .Clk(Clk), .Reset_al(rst_a), .bus(ifa.slave));
  mem_responder #(.WAIT_STATES(0), .DEPTH_LOG2(8)) dut_b (
    .Clk(Clk), .Reset_al(rst_b), .bus(ifb.slave));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; optionally scramble the inputs right after capture.
  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic perturb, output logic [15:0] rd, output logic e,
                      output int lat);
    @(negedge Clk);
    mem_en = 1'b1; we = w; addr = a; din = d;
    @(posedge Clk); #1;
    mem_en = 1'b0;
    if (perturb) begin
      addr = a ^ 16'h0001; din = ~d; we = ~w;
    end
    lat = 0; rd = 16'hxxxx; e = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      check("busy", {15'b0, busy}, 16'd1);
      if (r) begin
        lat = k; rd = dout; e = err;
        break;
      end
      @(posedge Clk); #1;
    end
    check("done", {15'b0, (lat != 0)}, 16'd1);
    @(posedge Clk); #1;
    check("r_clear", {15'b0, r}, 16'd0);
    check("busy_clear", {15'b0, busy}, 16'd0);
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; sel_b = 1'b0;
    mem_en = 1'b0; we = 1'b0; addr = '0; din = '0;
    #12;
    check("rst_r",    {15'b0, ifa.R},    16'd0);
    check("rst_busy", {15'b0, ifa.BUSY}, 16'd0);
    check("rst_err",  {15'b0, ifa.ERR},  16'd0);
    check("rst_dout", ifa.DATA_OUT,      16'h0000);
    check("rst_b_r",  {15'b0, ifb.R},    16'd0);
    @(negedge Clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // basic write / read, latency 3 with two wait states
    xact(1'b1, 16'h0010, 16'hBEEF, 1'b0, rd, e, lat);
    check("wr_lat", 16'(lat), 16'd3);
    check("wr_err", {15'b0, e}, 16'd0);
    xact(1'b0, 16'h0010, 16'h0000, 1'b0, rd, e, lat);
    check("rd_lat", 16'(lat), 16'd3);
    check("rd_data", rd, 16'hBEEF);
    xact(1'b1, 16'h0011, 16'h1234, 1'b0, rd, e, lat);
    check("wr_keeps_dout", rd, 16'hBEEF);
    check("wr_keeps_dout2", ifa.DATA_OUT, 16'hBEEF);

    // out-of-range accesses
    xact(1'b0, 16'h0100, 16'h0000, 1'b0, rd, e, lat);
    check("oor_rd_err", {15'b0, e}, 16'd1);
    check("oor_rd_data", rd, 16'h0000);
    xact(1'b1, 16'h8010, 16'hFFFF, 1'b0, rd, e, lat);
    check("oor_wr_err", {15'b0, e}, 16'd1);
    xact(1'b0, 16'h0010, 16'h0000, 1'b0, rd, e, lat);
    check("oor_wr_nowrap", rd, 16'hBEEF);
    check("inr_err", {15'b0, e}, 16'd0);

    // inputs changed during WAIT must not affect the access
    xact(1'b1, 16'h0031, 16'h7777, 1'b0, rd, e, lat);
    xact(1'b1, 16'h0030, 16'h5555, 1'b1, rd, e, lat);
    xact(1'b0, 16'h0030, 16'h0000, 1'b0, rd, e, lat);
    check("capt_addr30", rd, 16'h5555);
    xact(1'b0, 16'h0031, 16'h0000, 1'b0, rd, e, lat);
    check("capt_addr31", rd, 16'h7777);

    // reset in the middle of a write's wait phase
    xact(1'b1, 16'h0020, 16'h1111, 1'b0, rd, e, lat);
    @(negedge Clk);
    mem_en = 1'b1; we = 1'b1; addr = 16'h0020; din = 16'hAAAA;
    @(posedge Clk); #1;
    mem_en = 1'b0;
    check("abort_busy", {15'b0, ifa.BUSY}, 16'd1);
    @(posedge Clk); #2;
    rst_a = 1'b0;
    #1;
    check("abort_r",    {15'b0, ifa.R},    16'd0);
    check("abort_busy0", {15'b0, ifa.BUSY}, 16'd0);
    check("abort_dout", ifa.DATA_OUT, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      check("abort_no_r", {15'b0, ifa.R}, 16'd0);
    end
    @(negedge Clk);
    rst_a = 1'b1;
    xact(1'b0, 16'h0020, 16'h0000, 1'b0, rd, e, lat);
    check("abort_nowrite", rd, 16'h1111);

    // zero wait states, back-to-back reads with MEM_EN held high
    @(negedge Clk);
    sel_b = 1'b1;
    xact(1'b1, 16'h0010, 16'hBEEF, 1'b0, rd, e, lat);
    check("b_wr_lat", 16'(lat), 16'd1);
    xact(1'b1, 16'h0011, 16'h1234, 1'b0, rd, e, lat);
    @(negedge Clk);
    mem_en = 1'b1; we = 1'b0; addr = 16'h0010;
    @(posedge Clk); #1;
    check("b2b_r1", {15'b0, r}, 16'd1);
    check("b2b_d1", dout, 16'hBEEF);
    addr = 16'h0011;
    @(posedge Clk); #1;
    check("b2b_gap", {15'b0, r}, 16'd0);
    @(posedge Clk); #1;
    check("b2b_r3", {15'b0, r}, 16'd1);
    check("b2b_d3", dout, 16'h1234);
    mem_en = 1'b0;
    @(posedge Clk); #1;
    check("b2b_end", {15'b0, r}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
